speed_estimator: RTL and testbench
==================================

SPEED_ESTIMATOR -- requirements
Module: speed_estimator

Interface
REQ-001 Parameter: STALL_WINDOWS, 8, number of consecutive zero-count windows before stalled asserts (range 1..255).
REQ-002 Port: clk  input  1  system clock, all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: tick  input  1  measurement window gate; low clears the upstream encoder counter, high means counting.
REQ-005 Port: count_in  input  8  pulse count from the quadrature counter, unsigned, range 0..127.
REQ-006 Port: dir_in  input  1  rotation direction from the quadrature counter, 0 = cw, 1 = ccw.
REQ-007 Port: speed  output  9  signed two's-complement speed, mean of the last 4 window samples.
REQ-008 Port: sample  output  9  signed two's-complement value of the most recent single window.
REQ-009 Port: speed_valid  output  1  one-cycle strobe, speed and sample updated this cycle.
REQ-010 Port: stalled  output  1  motor considered stopped.
REQ-011 Port: overrun  output  1  sticky flag, a window end was dropped.

Function
REQ-012 Window end is detected when tick was 1 on the previous cycle and is 0 this cycle (falling edge); this is the capture cycle.
REQ-013 On the capture cycle, the block shall register count_in and dir_in, which still hold the final window value because the upstream counter clears only at the end of that cycle.
REQ-014 Signed sample shall be +count_in when dir_in = 0 and -count_in when dir_in = 1; count_in = 0 gives 0 regardless of dir_in.
REQ-015 The FSM shall have states SYNC, ACQ, CALC and OUT, with SYNC as the reset state.
REQ-016 SYNC: the first falling tick edge after reset shall be discarded (partial window) and the FSM shall go to ACQ; no output change.
REQ-017 ACQ: on the capture cycle, the FSM shall shift the sample into a 4-entry history (newest in, oldest dropped) and go to CALC.
REQ-018 CALC: the FSM shall form an 11-bit signed sum of the 4 history entries and go to OUT.
REQ-019 OUT: speed shall equal sum arithmetically shifted right by 2 (floor toward -inf); sample shall update; speed_valid shall be 1 for this cycle only; the FSM returns to ACQ.
REQ-020 Latency from the capture cycle to the speed_valid cycle shall be exactly 2 clocks.
REQ-021 speed and sample shall hold their values between strobes.
REQ-022 History entries shall be zero after reset, so speed ramps over the first 4 valid windows.
REQ-023 A falling tick edge seen in CALC or OUT shall be dropped, set overrun to 1, and leave the history unchanged.
REQ-024 overrun shall clear only on reset.
REQ-025 Stall counter (8 bits) shall increment in OUT when the sample is 0, saturating at STALL_WINDOWS, and shall clear in OUT when the sample is nonzero.
REQ-026 stalled shall be 1 exactly when the stall counter equals STALL_WINDOWS, and shall update in the same cycle as speed_valid.
REQ-027 tick held low for several cycles shall produce only one capture; tick held high shall produce no capture.

Reset
REQ-028 While reset = 1, the block shall set speed = 0, sample = 0, speed_valid = 0, stalled = 0, overrun = 0, history = 0, stall counter = 0, and FSM = SYNC.
REQ-029 Reset asserted in CALC or OUT shall abort the computation, with no speed_valid pulse issued on or after the reset cycle.
REQ-030 After reset release, the first window shall again be discarded as in REQ-016.

Verification
REQ-031 Reset, then windows with count_in = 40 and dir_in = 0 -> first window discarded; the next four strobes give sample = 40 and speed = 10, 20, 30, 40; each strobe occurs 2 clocks after its capture cycle.
REQ-032 Steady state at speed 40, then four windows with count_in = 20 and dir_in = 1 -> sample = -20; speed = 25, 10, -5, -20.
REQ-033 History {-1, 0, 0, 0} -> sum = -1, speed = -1 (floor); count_in = 127 with dir_in = 1 for 4 windows -> speed = -127, no overflow.
REQ-034 With STALL_WINDOWS = 3, zero-count windows -> stalled rises on the 3rd zero strobe and stays high; next window with count_in = 5 -> stalled = 0 on that strobe.
REQ-035 Second falling tick edge 1 cycle after a capture -> overrun = 1, history unchanged, exactly one speed_valid pulse; overrun persists until reset.
REQ-036 Reset pulsed during CALC -> no speed_valid, all outputs 0; the next falling edge is discarded and the one after it produces speed = sample / 4.

Source files
------------

// File: rtl/speed_estimator.sv
// Motor speed estimator: captures signed encoder counts at each window end
// and reports a 4-window moving average, a stall indication and an overrun flag.
module speed_estimator #(
    parameter int unsigned STALL_WINDOWS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [7:0]        count_in,
    input  logic              dir_in,
    output logic signed [8:0] speed,
    output logic signed [8:0] sample,
    output logic              speed_valid,
    output logic              stalled,
    output logic              overrun
);

    localparam int unsigned SW   = 9;
    localparam int unsigned SUMW = 11;
    localparam int unsigned CNTW = 8;
    localparam logic [CNTW-1:0] STALL_MAX = CNTW'(STALL_WINDOWS);

    localparam logic [1:0] SYNC = 2'd0;
    localparam logic [1:0] ACQ  = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   tick_q;
    logic                   fall_c;
    logic                   valid_q;
    logic signed [SW-1:0]   hist [0:3];
    logic signed [SW-1:0]   new_sample_c;
    logic signed [SUMW-1:0] sum_c;
    logic [CNTW-1:0]        stall_cnt;
    logic [CNTW-1:0]        stall_cnt_nxt_c;

    assign fall_c = tick_q & ~tick;

    // Sign the magnitude by direction; zero stays zero for either direction.
    always_comb begin
        new_sample_c = SW'(count_in);
        if (dir_in) begin
            new_sample_c = -SW'(count_in);
        end
    end

    always_comb begin
        sum_c = SUMW'(hist[0]) + SUMW'(hist[1]) + SUMW'(hist[2]) + SUMW'(hist[3]);
    end

    always_comb begin
        stall_cnt_nxt_c = '0;
        if (hist[0] == '0) begin
            stall_cnt_nxt_c = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SYNC: if (fall_c) state_nxt = ACQ;
            ACQ:  if (fall_c) state_nxt = CALC;
            CALC: state_nxt = OUT;
            OUT:  state_nxt = ACQ;
            default: state_nxt = SYNC;
        endcase
    end

    // Outputs are loaded at the end of CALC so they are visible during OUT,
    // two clocks after the capture cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q    <= 1'b0;
            valid_q   <= 1'b0;
            speed     <= '0;
            sample    <= '0;
            stalled   <= 1'b0;
            overrun   <= 1'b0;
            stall_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
        end else begin
            tick_q  <= tick;
            valid_q <= 1'b0;
            if (fall_c && (state == CALC || state == OUT)) begin
                overrun <= 1'b1;
            end
            if (state == ACQ && fall_c) begin
                hist[3] <= hist[2];
                hist[2] <= hist[1];
                hist[1] <= hist[0];
                hist[0] <= new_sample_c;
            end
            if (state == CALC) begin
                speed     <= SW'(sum_c >>> 2);
                sample    <= hist[0];
                valid_q   <= 1'b1;
                stall_cnt <= stall_cnt_nxt_c;
                stalled   <= (stall_cnt_nxt_c == STALL_MAX);
            end
        end
    end

    // A reset arriving in OUT must suppress the strobe already registered.
    assign speed_valid = valid_q & ~reset;

endmodule

// File: tb/tb_speed_estimator.sv
// Directed testbench for speed_estimator: averaging, floor rounding, stall,
// overrun and reset-abort behaviour against hand-computed values.
module tb_speed_estimator;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick;
    logic [7:0]        count_in;
    logic              dir_in;
    logic signed [8:0] speed;
    logic signed [8:0] sample;
    logic              speed_valid;
    logic              stalled;
    logic              overrun;

    int checks   = 0;
    int failures = 0;

    speed_estimator #(.STALL_WINDOWS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .count_in    (count_in),
        .dir_in      (dir_in),
        .speed       (speed),
        .sample      (sample),
        .speed_valid (speed_valid),
        .stalled     (stalled),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full window: count for 3 cycles, then tick low for the capture
    // cycle and the following CALC/OUT cycles.
    task automatic window(input logic [7:0] c, input logic d, input logic strobe,
                          input logic signed [15:0] exp_speed, input logic signed [15:0] exp_sample,
                          input logic exp_stalled);
        count_in = c;
        dir_in   = d;
        tick     = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        step();
        chk("valid_calc", 16'(speed_valid), 16'sd0);
        step();
        chk("valid_out", 16'(speed_valid), 16'(strobe));
        if (strobe) begin
            chk("speed", speed, exp_speed);
            chk("sample", sample, exp_sample);
        end
        chk("stalled", 16'(stalled), 16'(exp_stalled));
        step();
        chk("valid_after", 16'(speed_valid), 16'sd0);
        if (strobe) chk("speed_hold", speed, exp_speed);
        step();
        chk("valid_idle", 16'(speed_valid), 16'sd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        count_in = 8'd0;
        dir_in   = 1'b0;
        do_reset();
        chk("rst_speed", speed, 16'sd0);
        chk("rst_sample", sample, 16'sd0);
        chk("rst_valid", 16'(speed_valid), 16'sd0);
        chk("rst_stalled", 16'(stalled), 16'sd0);
        chk("rst_overrun", 16'(overrun), 16'sd0);

        // Ramp at +40: first window discarded
        window(8'd40, 1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
        window(8'd40, 1'b0, 1'b1, 16'sd10, 16'sd40, 1'b0);
        window(8'd40, 1'b0, 1'b1, 16'sd20, 16'sd40, 1'b0);
        window(8'd40, 1'b0, 1'b1, 16'sd30, 16'sd40, 1'b0);
        window(8'd40, 1'b0, 1'b1, 16'sd40, 16'sd40, 1'b0);

        // Reverse at -20
        window(8'd20, 1'b1, 1'b1, 16'sd25, -16'sd20, 1'b0);
        window(8'd20, 1'b1, 1'b1, 16'sd10, -16'sd20, 1'b0);
        window(8'd20, 1'b1, 1'b1, -16'sd5, -16'sd20, 1'b0);
        window(8'd20, 1'b1, 1'b1, -16'sd20, -16'sd20, 1'b0);

        // Floor rounding and full-scale negative
        do_reset();
        window(8'd1, 1'b1, 1'b0, 16'sd0, 16'sd0, 1'b0);
        window(8'd1, 1'b1, 1'b1, -16'sd1, -16'sd1, 1'b0);
        window(8'd127, 1'b1, 1'b1, -16'sd32, -16'sd127, 1'b0);
        window(8'd127, 1'b1, 1'b1, -16'sd64, -16'sd127, 1'b0);
        window(8'd127, 1'b1, 1'b1, -16'sd96, -16'sd127, 1'b0);
        window(8'd127, 1'b1, 1'b1, -16'sd127, -16'sd127, 1'b0);

        // Stall detection with STALL_WINDOWS = 3
        window(8'd0, 1'b0, 1'b1, -16'sd96, 16'sd0, 1'b0);
        window(8'd0, 1'b1, 1'b1, -16'sd64, 16'sd0, 1'b0);
        window(8'd0, 1'b0, 1'b1, -16'sd32, 16'sd0, 1'b1);
        window(8'd0, 1'b0, 1'b1, 16'sd0, 16'sd0, 1'b1);
        window(8'd5, 1'b0, 1'b1, 16'sd1, 16'sd5, 1'b0);
        chk("overrun_clean", 16'(overrun), 16'sd0);

        // Extra falling edge during OUT is dropped and flagged
        count_in = 8'd8;
        dir_in   = 1'b0;
        tick     = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        step();
        tick = 1'b1;
        step();
        chk("ovr_valid", 16'(speed_valid), 16'sd1);
        chk("ovr_speed", speed, 16'sd3);
        tick = 1'b0;
        step();
        chk("ovr_valid_after", 16'(speed_valid), 16'sd0);
        chk("ovr_flag", 16'(overrun), 16'sd1);
        repeat (3) begin
            step();
            chk("ovr_no_pulse", 16'(speed_valid), 16'sd0);
        end
        window(8'd4, 1'b0, 1'b1, 16'sd4, 16'sd4, 1'b0);
        chk("ovr_sticky", 16'(overrun), 16'sd1);

        // Reset during CALC aborts the computation
        count_in = 8'd40;
        dir_in   = 1'b0;
        tick     = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("abort_valid", 16'(speed_valid), 16'sd0);
        chk("abort_speed", speed, 16'sd0);
        chk("abort_sample", sample, 16'sd0);
        chk("abort_stalled", 16'(stalled), 16'sd0);
        chk("abort_overrun", 16'(overrun), 16'sd0);
        reset = 1'b0;
        step();
        chk("abort_valid2", 16'(speed_valid), 16'sd0);
        window(8'd40, 1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0);
        window(8'd40, 1'b0, 1'b1, 16'sd10, 16'sd40, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
